rom_line_cache: RTL and testbench
=================================

# rom_line_cache

Parametrised read-only, direct-mapped cache with multi-word line fill. It sits between a CPU program-ROM read port and the SDRAM burst read channel. It also adds a single-cycle flush and configurable address, data, index and line widths. Hits are served from on-chip block RAM; each miss fetches a full line from SDRAM in one burst and returns the requested word as soon as the line is filled.

## Interface
- `ADDR_W`, 18, word address width.
- `DATA_W`, 16, data word width.
- `INDEX_W`, 9, line-index bits; 2^INDEX_W lines.
- `LINE_W`, 2, offset bits; 2^LINE_W words per line.
- Derived: `TAG_W = ADDR_W - INDEX_W - LINE_W`, must be ≥1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  one-cycle pulse; invalidates every line.
- `cache_req`  in  1  level read request, held until served.
- `cache_addr`  in  ADDR_W  word address; sampled when a request is accepted.
- `cache_valid`  out  1  registered; requested data valid.
- `cache_data`  out  DATA_W  registered read data.
- `rom_req`  out  1  level; held high for a whole line burst.
- `rom_addr`  out  ADDR_W  line base address, offset bits zero; stable while `rom_req` is high.
- `rom_data`  in  DATA_W  burst word.
- `rom_valid`  in  1  one pulse per burst word, in ascending offset order.

## Operation
- Address fields:
  - tag = `addr[ADDR_W-1:INDEX_W+LINE_W]`
  - index = `addr[INDEX_W+LINE_W-1:LINE_W]`
  - offset = `addr[LINE_W-1:0]`
- Storage:
  - data RAM: 2^(INDEX_W+LINE_W) × DATA_W.
  - tag RAM: 2^INDEX_W × TAG_W.
  - valid bits: 2^INDEX_W flops, so they can be cleared in one cycle.
- States: IDLE, LOOKUP, FILL, HIT.
- IDLE:
  - If `cache_req` is high: latch `cache_addr` into `addr_r`, issue tag and data RAM reads, go to LOOKUP.
- LOOKUP:
  - Hit (valid[index] and tag match): register the RAM word into `cache_data`, set `cache_valid`, go to HIT.
  - Otherwise: set `rom_req`, drive `rom_addr` = {tag, index, 0}, clear the word counter k, go to FILL.
- FILL:
  - On each `rom_valid`: write `rom_data` to data RAM at {index, k}.
  - If k == offset, capture the word into `data_r`.
  - Then increment k.
  - On the word where k == 2^LINE_W−1: drop `rom_req` and write the tag.
  - On that same word, set valid[index], unless a flush occurred during this fill.
  - Next state: if `cache_req` is high and `cache_addr` == `addr_r`, go to HIT with `cache_data` = `data_r` and `cache_valid` = 1. Otherwise go to IDLE.
  - The fill always completes, even if the requester drops or changes its request; SDRAM bursts are not aborted.
- HIT:
  - Hold `cache_valid` and `cache_data` while `cache_req` is high and `cache_addr` == `addr_r`.
  - If `cache_req` goes low: go to IDLE; `cache_valid` is 0 next cycle.
  - If the address changes with `cache_req` high: latch the new address, go to LOOKUP; `cache_valid` is 0 next cycle.
- Flush:
  - Clears all valid bits in the cycle after the pulse.
  - During FILL, it also sets a `flushed` flag so the in-flight line is not marked valid. The flag clears at the end of the fill.
  - Flush in any other state does not change the state.
  - Flush and the last-word valid write in the same cycle: the flush wins and the line stays invalid.
- Reset:
  - State goes to IDLE; all valid bits, `flushed` and k are cleared.
  - Outputs: `cache_valid` = 0, `rom_req` = 0, `cache_data` = 0, `rom_addr` = 0.
  - Reset during FILL abandons the burst and drops `rom_req` in the next cycle. The SDRAM side must tolerate stray `rom_valid` pulses, which the cache ignores in IDLE.
- The tag and data RAM contents are not cleared by reset or flush.

## Timing
- Request first seen high in IDLE at cycle N: LOOKUP at N+1; on a hit, `cache_valid` is high at N+2.
- Back-to-back hits via address change in HIT: one result every 2 cycles.
- Miss:
  - `rom_req` is high from N+2.
  - The last `rom_valid` arrives at cycle M; `cache_valid` is high at M+1, and `rom_req` is low at M+1.
- The `rom_valid` pulse on the cycle after `rom_req` falls is never expected; the cache ignores it.
- A new fill can start no earlier than 2 cycles after the previous one ends: IDLE, then LOOKUP.
- Data RAM read latency: 1 cycle. The write and the read in the same cycle never target the same state path.

## Test plan
- Cold read at 0x00005 (defaults): a miss, so `rom_req` rises with `rom_addr` = 0x00004. Feed 4 words 0xA0..0xA3; `cache_valid` is high one cycle after the 4th word, with `cache_data` = 0xA1.
- Re-read 0x00004, then 0x00007, with `cache_req` held and the address changed: each returns valid 2 cycles after its address, with data 0xA0 and 0xA3. `rom_req` stays low.
- Read 0x00804 (same index, different tag): a refill with `rom_addr` = 0x00804. Afterwards, 0x00004 misses again.
- Flush during the 2nd word of a fill: the fill completes and data is returned, but an immediate re-read of the same address misses and refills.
- Drop `cache_req` mid-fill: `rom_req` stays high until the 4th word, then IDLE with `cache_valid` = 0. A later read of the same line hits in 2 cycles.
- Assert reset mid-fill: `rom_req` is 0 the next cycle, `cache_valid` is 0, and a subsequent read of any prior line misses.

Source files
------------

// File: rtl/rom_line_cache.sv
// rom_line_cache: read-only, direct-mapped cache between a CPU program-ROM read
// port and an SDRAM burst read channel. A hit is served from block RAM; a miss
// fetches the whole line in one burst and returns the requested word once the
// line is complete. The flush input invalidates every line in a single cycle.
module rom_line_cache #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 9,
  parameter int LINE_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic              cache_valid,
  output logic [DATA_W-1:0] cache_data,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_valid
);

  localparam int TAG_W  = ADDR_W - INDEX_W - LINE_W;
  localparam int RAM_AW = INDEX_W + LINE_W;  // data RAM word address width
  localparam int LINES  = 1 << INDEX_W;
  localparam int WORDS  = 1 << RAM_AW;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, HIT} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_r;
  logic [LINE_W-1:0]   k;
  logic                flushed;
  logic [LINES-1:0]    valid;
  logic [DATA_W-1:0]   data_r;

  logic [DATA_W-1:0]   data_mem [WORDS];
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   ram_q;
  logic [TAG_W-1:0]    tag_q;

  // Address fields of the incoming request and of the latched request.
  logic [INDEX_W-1:0]  req_index;
  logic [RAM_AW-1:0]   req_word;
  logic [TAG_W-1:0]    r_tag;
  logic [INDEX_W-1:0]  r_index;
  logic [LINE_W-1:0]   r_offset;

  assign req_index = cache_addr[RAM_AW-1:LINE_W];
  assign req_word  = cache_addr[RAM_AW-1:0];
  assign r_tag     = addr_r[ADDR_W-1:RAM_AW];
  assign r_index   = addr_r[RAM_AW-1:LINE_W];
  assign r_offset  = addr_r[LINE_W-1:0];

  // A new address is accepted from IDLE, or from HIT when the address moves.
  logic accept;
  logic fill_we;
  logic last_word;
  logic same_req;
  logic hit;
  logic [DATA_W-1:0] fill_word;

  assign accept    = cache_req && ((state == IDLE) ||
                                   ((state == HIT) && (cache_addr != addr_r)));
  assign fill_we   = (state == FILL) && rom_valid;
  assign last_word = fill_we && (&k);
  assign same_req  = cache_req && (cache_addr == addr_r);
  assign hit       = valid[r_index] && (tag_q == r_tag);
  // The requested word may be arriving on the very last beat of the burst.
  assign fill_word = (k == r_offset) ? rom_data : data_r;

  // Data RAM: burst writes during FILL, one-cycle registered read on accept.
  // NOTE: RAM arrays are deliberately left out of reset so they map onto block
  // RAM; the valid flops alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (fill_we) data_mem[{r_index, k}] <= rom_data;
    if (accept)  ram_q <= data_mem[req_word];
  end

  // Tag RAM: written on the last beat of a fill, read alongside the data RAM.
  always_ff @(posedge clk) begin
    if (last_word) tag_mem[r_index] <= r_tag;
    if (accept)    tag_q <= tag_mem[req_index];
  end

  // Control FSM with registered outputs, valid bits and the flush bookkeeping.
  // NOTE: every register here uses non-blocking assignment so all of them see
  // the pre-edge values; later assignments (the flush clear) override earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= '0;
      flushed     <= 1'b0;
      k           <= '0;
      cache_valid <= 1'b0;
      cache_data  <= '0;
      rom_req     <= 1'b0;
      rom_addr    <= '0;
      addr_r      <= '0;
      data_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cache_req) begin
            addr_r <= cache_addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cache_data  <= ram_q;
            cache_valid <= 1'b1;
            state       <= HIT;
          end else begin
            rom_req  <= 1'b1;
            rom_addr <= {r_tag, r_index, {LINE_W{1'b0}}};
            k        <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (flush) flushed <= 1'b1;
          if (rom_valid) begin
            if (k == r_offset) data_r <= rom_data;
            k <= k + 1'b1;
            if (&k) begin
              rom_req <= 1'b0;
              flushed <= 1'b0;
              if (!flushed && !flush) valid[r_index] <= 1'b1;
              if (same_req) begin
                cache_data  <= fill_word;
                cache_valid <= 1'b1;
                state       <= HIT;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        HIT: begin
          if (!cache_req) begin
            cache_valid <= 1'b0;
            state       <= IDLE;
          end else if (cache_addr != addr_r) begin
            cache_valid <= 1'b0;
            addr_r      <= cache_addr;
            state       <= LOOKUP;
          end
        end
      endcase
      // Flush wins over any valid-bit set in the same cycle.
      if (flush) valid <= '0;
    end
  end

endmodule

// File: tb/tb_rom_line_cache.sv
// Bench for rom_line_cache: directed scenarios plus a randomized read stream.
// A line-level model (valid/tag per index) predicts hit or miss, and the ROM
// contents come from a fixed function of the word address.
module tb_rom_line_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        cache_req;
  logic [17:0] cache_addr;
  logic        cache_valid;
  logic [15:0] cache_data;
  logic        rom_req;
  logic [17:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_valid;

  int errors = 0;
  int checks = 0;

  bit         m_valid [512];
  logic [6:0] m_tag   [512];

  always #5 clk = ~clk;

  rom_line_cache dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .cache_req   (cache_req),
    .cache_addr  (cache_addr),
    .cache_valid (cache_valid),
    .cache_data  (cache_data),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rom_valid   (rom_valid)
  );

  // Backing ROM contents: 0x4..0x7 hold 0xA0..0xA3, everything else a hash.
  function automatic logic [15:0] rom_word(input logic [17:0] a);
    if (a >= 18'd4 && a <= 18'd7) return 16'h00A0 + 16'(a - 18'd4);
    return 16'(a * 18'd40503) ^ 16'h1234;
  endfunction

  task automatic model_flush();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // One read: presents addr at the current negedge, predicts hit or miss from
  // the model, serves the burst on a miss. flush_at/drop_at pick the burst word
  // on which flush pulses or cache_req drops (-1 = never).
  task automatic do_read(input logic [17:0] addr, input int flush_at, input int drop_at);
    logic [8:0]  idx;
    logic [6:0]  tag;
    logic [17:0] base;
    logic [15:0] exp_data;
    logic        hit_exp;
    bit          fill_flushed;
    idx          = addr[10:2];
    tag          = addr[17:11];
    base         = {addr[17:2], 2'b00};
    exp_data     = rom_word(addr);
    hit_exp      = m_valid[idx] && (m_tag[idx] == tag);
    fill_flushed = 1'b0;
    cache_req    = 1'b1;
    cache_addr   = addr;
    @(negedge clk);
    checks++;
    if (cache_valid !== 1'b0 || rom_req !== 1'b0) begin
      errors++;
      $display("FAIL lookup addr=%h: got valid=%b rom_req=%b, expected 0/0", addr, cache_valid, rom_req);
    end
    @(negedge clk);
    if (hit_exp) begin
      checks++;
      if (cache_valid !== 1'b1 || cache_data !== exp_data || rom_req !== 1'b0) begin
        errors++;
        $display("FAIL hit addr=%h: got valid=%b data=%h rom_req=%b, expected 1/%h/0",
                 addr, cache_valid, cache_data, rom_req, exp_data);
      end
    end else begin
      checks++;
      if (rom_req !== 1'b1 || rom_addr !== base || cache_valid !== 1'b0) begin
        errors++;
        $display("FAIL miss_start addr=%h: got rom_req=%b rom_addr=%h valid=%b, expected 1/%h/0",
                 addr, rom_req, rom_addr, cache_valid, base);
      end
      for (int w = 0; w < 4; w++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        checks++;
        if (rom_req !== 1'b1 || cache_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill_busy addr=%h word=%0d: got rom_req=%b valid=%b, expected 1/0",
                   addr, w, rom_req, cache_valid);
        end
        rom_valid = 1'b1;
        rom_data  = rom_word(base | 18'(w));
        if (w == flush_at) begin
          flush        = 1'b1;
          fill_flushed = 1'b1;
          model_flush();
        end
        if (w == drop_at) cache_req = 1'b0;
        @(negedge clk);
        rom_valid = 1'b0;
        rom_data  = '0;
        flush     = 1'b0;
      end
      m_tag[idx] = tag;
      if (!fill_flushed) m_valid[idx] = 1'b1;
      checks++;
      if (drop_at >= 0) begin
        if (cache_valid !== 1'b0 || rom_req !== 1'b0) begin
          errors++;
          $display("FAIL fill_end_dropped addr=%h: got valid=%b rom_req=%b, expected 0/0",
                   addr, cache_valid, rom_req);
        end
      end else begin
        if (cache_valid !== 1'b1 || cache_data !== exp_data || rom_req !== 1'b0) begin
          errors++;
          $display("FAIL fill_end addr=%h: got valid=%b data=%h rom_req=%b, expected 1/%h/0",
                   addr, cache_valid, cache_data, rom_req, exp_data);
        end
      end
    end
  endtask

  task automatic release_req();
    cache_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cache_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: got valid=%b, expected 0", cache_valid);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    flush      = 1'b0;
    cache_req  = 1'b0;
    cache_addr = '0;
    rom_valid  = 1'b0;
    rom_data   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cache_valid !== 1'b0 || rom_req !== 1'b0 || cache_data !== 16'h0 || rom_addr !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b rom_req=%b data=%h rom_addr=%h, expected all 0",
               cache_valid, rom_req, cache_data, rom_addr);
    end
    reset = 1'b0;
    model_flush();
    @(negedge clk);
    checks++;
    if (cache_valid !== 1'b0 || rom_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got valid=%b rom_req=%b, expected 0/0", cache_valid, rom_req);
    end
  endtask

  task automatic test_cold_miss();
    do_read(18'h00005, -1, -1);
    checks++;
    if (cache_data !== 16'h00A1) begin
      errors++;
      $display("FAIL cold_data: got %h, expected 00a1", cache_data);
    end
  endtask

  task automatic test_back_to_back();
    do_read(18'h00004, -1, -1);
    @(negedge clk);
    checks++;
    if (cache_valid !== 1'b1 || cache_data !== 16'h00A0) begin
      errors++;
      $display("FAIL hit_hold: got valid=%b data=%h, expected 1/00a0", cache_valid, cache_data);
    end
    do_read(18'h00007, -1, -1);
    release_req();
  endtask

  task automatic test_conflict();
    do_read(18'h00804, -1, -1);
    release_req();
    do_read(18'h00004, -1, -1);
    release_req();
  endtask

  task automatic test_flush_fill();
    do_read(18'h00100, 1, -1);
    release_req();
    do_read(18'h00100, -1, -1);
    release_req();
    do_read(18'h00200, 3, -1);
    release_req();
    do_read(18'h00201, -1, -1);
    release_req();
  endtask

  task automatic test_drop_mid_fill();
    do_read(18'h01008, -1, 1);
    release_req();
    do_read(18'h0100A, -1, -1);
    release_req();
  endtask

  task automatic test_reset_mid_fill();
    cache_req  = 1'b1;
    cache_addr = 18'h03F0C;
    repeat (2) @(negedge clk);
    checks++;
    if (rom_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_fill_start: got rom_req=%b, expected 1", rom_req);
    end
    for (int w = 0; w < 2; w++) begin
      rom_valid = 1'b1;
      rom_data  = rom_word(18'h03F0C | 18'(w));
      @(negedge clk);
      rom_valid = 1'b0;
    end
    reset     = 1'b1;
    cache_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rom_req !== 1'b0 || cache_valid !== 1'b0 || cache_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_fill: got rom_req=%b valid=%b data=%h, expected 0/0/0",
               rom_req, cache_valid, cache_data);
    end
    reset = 1'b0;
    model_flush();
    // Stray burst beat after the abandoned fill must be ignored.
    rom_valid = 1'b1;
    rom_data  = 16'hDEAD;
    @(negedge clk);
    rom_valid = 1'b0;
    rom_data  = '0;
    @(negedge clk);
    checks++;
    if (rom_req !== 1'b0 || cache_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_beat: got rom_req=%b valid=%b, expected 0/0", rom_req, cache_valid);
    end
    do_read(18'h00005, -1, -1);
    release_req();
    do_read(18'h0100A, -1, -1);
    release_req();
  endtask

  task automatic test_random();
    logic [17:0] a;
    logic [17:0] cur;
    bit          held;
    held = 1'b0;
    cur  = '0;
    for (int n = 0; n < 40; n++) begin
      a = {7'($urandom_range(0, 3)), 9'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (held && a == cur) begin
        release_req();
        held = 1'b0;
      end
      if (!held && $urandom_range(0, 3) == 0) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
      end
      do_read(a, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
      cur  = a;
      held = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        release_req();
        held = 1'b0;
      end
    end
    if (held) release_req();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_flush_fill();
    test_drop_mid_fill();
    test_reset_mid_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
